phys_free_list: RTL and testbench
=================================

// Module: phys_free_list
// PURPOSE
//  Circular FIFO of free physical register tags for the rename stage. It feeds
//  dest_phys_new into the id_ex register and reclaims dest_phys_old at commit.
//  It keeps a committed read pointer, so a flush returns every speculatively
//  allocated tag in one cycle.
// PARAMETERS
//  NUM_PHYS  64                  total physical registers
//  NUM_ARCH  32                  architectural registers (p0..p31 = x0..x31 at reset)
//  PHYS_W    $clog2(NUM_PHYS)=6  tag width
//  DEPTH     NUM_PHYS-NUM_ARCH   list capacity (32)
// PORTS
//  clk             in   1       clock; all state updates on rising edge
//  rst_n           in   1       asynchronous, active-low reset
//  alloc_req       in   1       rename wants a tag (asserted only when dest_arch != 0)
//  alloc_valid     out  1       a free tag is available
//  alloc_phys      out  PHYS_W  tag at head; consumed when alloc_req && alloc_valid
//  commit_valid    in   1       a tag-allocating instruction retires
//  commit_phys_old in   PHYS_W  dest_phys_old of the retiring instruction; returned to list
//  flush           in   1       mispredict/exception; discard speculative allocations
//  free_count      out  PTR_W   entries between head and tail (0..DEPTH)
//  err_overflow    out  1       sticky: illegal return (list full, or tag 0)
// BEHAVIOUR
//  - State: mem[DEPTH] of PHYS_W, plus three PTR_W=$clog2(DEPTH)+1 pointers.
//    The MSB of each pointer is a wrap bit.
//      head     alloc read pointer
//      tail     free write pointer
//      c_head   committed head
//  - Reset (async, rst_n=0):
//      mem[i]=NUM_ARCH+i; head=0; c_head=0; tail={1'b1,0} (full); err_overflow=0
//      Outputs: alloc_valid=1, alloc_phys=32, free_count=DEPTH.
//  - Combinational outputs, from registered state only (no bypass):
//      alloc_valid = (head!=tail) && !flush
//      alloc_phys  = mem[head[PTR_W-2:0]]
//      free_count  = tail-head (PTR_W arithmetic, modulo 2^PTR_W)
//  - Alloc fire = alloc_req && alloc_valid: head+=1 next cycle; alloc latency 0 (same-cycle tag).
//    alloc_req with alloc_valid=0 is a stall: no state change; the renamer holds the instruction.
//  - Commit (commit_valid, legal):
//      mem[tail]<=commit_phys_old; tail+=1; c_head+=1 (retiring instr consumed a tag at rename).
//  - Illegal commit (free_count==DEPTH or commit_phys_old==0):
//      write dropped, no pointer moves, err_overflow<=1 until reset.
//  - Freed tag is allocatable the cycle after the commit edge. When the list is empty,
//    a same-cycle commit does not make alloc_valid=1.
//  - Flush:
//      head<=c_head_next (c_head after any same-cycle commit increment);
//      alloc fire suppressed that cycle; tail unaffected.
//    Result: free_count equals the committed free count the cycle after.
//  - Simultaneous alloc+commit: both apply; free_count unchanged.
//  - Pointer wrap: index = ptr[PTR_W-2:0]; full/empty distinguished by wrap bit.
//  - rst_n asserted mid-operation: all state returns to reset values immediately
//    (async); in-flight alloc/commit lost.
// STRUCTURE
//  - rv32i_types gains: typedef logic [5:0] phys_reg_t; localparam NUM_PHYS=64, NUM_ARCH=32.
//    id_ex/ex_mem/mem_wb phys fields retype to phys_reg_t.
//  - Single module, no sub-module; pointer/mem logic in one always_ff, outputs in always_comb.
// TESTING
//  1 Reset release -> alloc_valid=1, alloc_phys=32, free_count=32, err_overflow=0.
//  2 32 back-to-back allocs -> tags 32..63 in order, then alloc_valid=0, free_count=0;
//    33rd alloc_req stalls with no state change.
//  3 List empty; commit phys_old=5 -> same cycle alloc_valid=0;
//    next cycle alloc_valid=1, alloc_phys=5, free_count=1.
//  4 From reset: 3 allocs (32,33,34), 1 commit (old=7), then flush -> next cycle
//    alloc_phys=33, free_count=32; following alloc order 33,34,...,63,7.
//  5 Commit+flush same cycle after 2 allocs -> head=c_head=1, tail wraps, free_count=32;
//    alloc_valid=0 in flush cycle.
//  6 At reset state, commit old=9 -> err_overflow=1 (sticky), free_count stays 32;
//    also commit old=0 -> err. Assert rst_n mid-alloc -> reset values.

Source files
------------

// File: rtl/phys_free_list_pkg.sv
// Shared rename-stage types and sizing for the physical register free list.
//   NUM_PHYS / NUM_ARCH : physical and architectural register counts
//   PHYS_W              : physical tag width
//   DEPTH               : free-list capacity (tags not bound to an arch reg at reset)
//   PTR_W               : free-list pointer width, MSB is the wrap bit
package phys_free_list_pkg;

  localparam int unsigned NUM_PHYS = 64;
  localparam int unsigned NUM_ARCH = 32;
  localparam int unsigned PHYS_W   = $clog2(NUM_PHYS);
  localparam int unsigned DEPTH    = NUM_PHYS - NUM_ARCH;
  localparam int unsigned PTR_W    = $clog2(DEPTH) + 1;

  typedef logic [PHYS_W-1:0] phys_reg_t;
  typedef logic [PTR_W-1:0]  fl_ptr_t;

endpackage

// File: rtl/phys_free_list.sv
// Circular FIFO of free physical register tags for the rename stage.
// Allocation reads speculatively at head; commit returns dest_phys_old at
// tail and advances the committed head c_head. A flush snaps head back to
// c_head, returning every speculatively allocated tag in one cycle.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   alloc_req        rename wants a tag this cycle
//   alloc_valid      a free tag is available (forced low during flush)
//   alloc_phys       tag at head, consumed when alloc_req && alloc_valid
//   commit_valid     a tag-allocating instruction retires
//   commit_phys_old  its previous mapping, returned to the list
//   flush            discard speculative allocations
//   free_count       tail - head, 0..DEPTH
//   err_overflow     sticky: illegal return (list full or tag 0)
module phys_free_list
  import phys_free_list_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_req,
  output logic              alloc_valid,
  output logic [PHYS_W-1:0] alloc_phys,
  input  logic              commit_valid,
  input  logic [PHYS_W-1:0] commit_phys_old,
  input  logic              flush,
  output logic [PTR_W-1:0]  free_count,
  output logic              err_overflow
);

  localparam fl_ptr_t PTR_FULL = {1'b1, {(PTR_W-1){1'b0}}};
  localparam fl_ptr_t DEPTH_P  = fl_ptr_t'(DEPTH);

  phys_reg_t mem_q [DEPTH];
  fl_ptr_t   head_q;
  fl_ptr_t   tail_q;
  fl_ptr_t   c_head_q;
  logic      err_q;

  logic      alloc_fire;
  logic      commit_ok;
  logic      commit_bad;
  fl_ptr_t   c_head_next;
  fl_ptr_t   head_next;
  fl_ptr_t   tail_next;

  // Outputs come from registered state only; a same-cycle commit into an
  // empty list does not make a tag visible until the next cycle.
  always_comb begin
    free_count   = tail_q - head_q;
    alloc_valid  = (head_q != tail_q) && !flush;
    alloc_phys   = mem_q[head_q[PTR_W-2:0]];
    err_overflow = err_q;
  end

  always_comb begin
    alloc_fire  = alloc_req && alloc_valid;
    commit_bad  = commit_valid &&
                  ((free_count == DEPTH_P) || (commit_phys_old == '0));
    commit_ok   = commit_valid && !commit_bad;
    c_head_next = c_head_q + fl_ptr_t'(commit_ok);
    tail_next   = tail_q + fl_ptr_t'(commit_ok);
    // Flush restores head to the committed point including this cycle's
    // retirement; alloc_valid is already low, so no alloc can fire.
    if (flush) begin
      head_next = c_head_next;
    end else begin
      head_next = head_q + fl_ptr_t'(alloc_fire);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= phys_reg_t'(NUM_ARCH + i);
      end
      head_q   <= '0;
      c_head_q <= '0;
      tail_q   <= PTR_FULL;
      err_q    <= 1'b0;
    end else begin
      if (commit_ok) begin
        mem_q[tail_q[PTR_W-2:0]] <= commit_phys_old;
      end
      head_q   <= head_next;
      c_head_q <= c_head_next;
      tail_q   <= tail_next;
      if (commit_bad) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phys_free_list.sv
// Self-checking bench for phys_free_list. A queue model of the free list
// (plus a queue of speculatively allocated tags for flush recovery) predicts
// outputs; allocated tags go to a scoreboard and are popped on the DUT side.
module tb_phys_free_list;

  logic       clk;
  logic       rst_n;
  logic       alloc_req;
  logic       alloc_valid;
  logic [5:0] alloc_phys;
  logic       commit_valid;
  logic [5:0] commit_phys_old;
  logic       flush;
  logic [5:0] free_count;
  logic       err_overflow;

  phys_free_list dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alloc_req       (alloc_req),
    .alloc_valid     (alloc_valid),
    .alloc_phys      (alloc_phys),
    .commit_valid    (commit_valid),
    .commit_phys_old (commit_phys_old),
    .flush           (flush),
    .free_count      (free_count),
    .err_overflow    (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [5:0] free_q [$];
  logic [5:0] spec_q [$];
  logic [5:0] exp_q  [$];
  logic       err_m;

  logic       exp_valid;
  logic       exp_fire;
  logic [5:0] exp_count;
  logic [5:0] exp_head;
  logic       exp_err;

  task automatic model_init();
    free_q.delete();
    spec_q.delete();
    exp_q.delete();
    for (int i = 0; i < 32; i++) free_q.push_back(6'(32 + i));
    err_m = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    alloc_req = 1'b0; commit_valid = 1'b0; commit_phys_old = '0; flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_init();
  endtask

  // Drive one cycle of stimulus at the falling edge and predict the outputs
  // visible before the next rising edge, then advance the model past it.
  task automatic drive(input logic req, input logic cv, input logic [5:0] old,
                       input logic fl);
    logic       legal;
    logic [5:0] t;
    @(negedge clk);
    alloc_req = req; commit_valid = cv; commit_phys_old = old; flush = fl;
    exp_valid = (free_q.size() != 0) && !fl;
    exp_count = 6'(free_q.size());
    exp_head  = (free_q.size() != 0) ? free_q[0] : 6'd0;
    exp_err   = err_m;
    exp_fire  = req && exp_valid;
    legal     = cv && (free_q.size() != 32) && (old != 6'd0);
    if (exp_fire) begin
      t = free_q.pop_front();
      exp_q.push_back(t);
      spec_q.push_back(t);
    end
    if (legal) begin
      free_q.push_back(old);
      if (spec_q.size() != 0) void'(spec_q.pop_front());
    end else if (cv) begin
      err_m = 1'b1;
    end
    if (fl) begin
      for (int i = spec_q.size() - 1; i >= 0; i--) free_q.push_front(spec_q[i]);
      spec_q.delete();
    end
    #2;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    do_reset();
    drive(1'b0, 1'b0, 6'd0, 1'b0);
    n_cmp++; if (alloc_valid !== 1'b1) begin n_bad++; $display("FAIL reset_valid: got %0b want 1", alloc_valid); end
    n_cmp++; if (alloc_phys !== 6'd32) begin n_bad++; $display("FAIL reset_phys: got %0d want 32", alloc_phys); end
    n_cmp++; if (free_count !== 6'd32) begin n_bad++; $display("FAIL reset_count: got %0d want 32", free_count); end
    n_cmp++; if (err_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b want 0", err_overflow); end
    got = alloc_phys;
    n_cmp++; if (got !== exp_head) begin n_bad++; $display("FAIL reset_head_model: got %0d want %0d", got, exp_head); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] e;
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 6'd0, 1'b0);
      n_cmp++; if (alloc_valid !== exp_valid) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %0b want %0b", i, alloc_valid, exp_valid); end
      n_cmp++; if (free_count !== exp_count) begin n_bad++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, free_count, exp_count); end
      if (exp_fire) begin
        e = exp_q.pop_front();
        n_cmp++; if (alloc_phys !== e) begin n_bad++; $display("FAIL b2b_tag[%0d]: got %0d want %0d", i, alloc_phys, e); end
      end
    end
    // 33rd request stalls; state must not move across two stalled cycles
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 6'd0, 1'b0);
      n_cmp++; if (alloc_valid !== 1'b0) begin n_bad++; $display("FAIL empty_valid[%0d]: got %0b want 0", i, alloc_valid); end
      n_cmp++; if (free_count !== 6'd0) begin n_bad++; $display("FAIL empty_count[%0d]: got %0d want 0", i, free_count); end
    end
  endtask

  task automatic test_commit_empty();
    drive(1'b1, 1'b1, 6'd5, 1'b0);
    n_cmp++; if (alloc_valid !== 1'b0) begin n_bad++; $display("FAIL commit_empty_same: got %0b want 0", alloc_valid); end
    drive(1'b0, 1'b0, 6'd0, 1'b0);
    n_cmp++; if (alloc_valid !== 1'b1) begin n_bad++; $display("FAIL commit_empty_valid: got %0b want 1", alloc_valid); end
    n_cmp++; if (alloc_phys !== 6'd5) begin n_bad++; $display("FAIL commit_empty_phys: got %0d want 5", alloc_phys); end
    n_cmp++; if (free_count !== 6'd1) begin n_bad++; $display("FAIL commit_empty_count: got %0d want 1", free_count); end
    n_cmp++; if (alloc_phys !== exp_head) begin n_bad++; $display("FAIL commit_empty_model: got %0d want %0d", alloc_phys, exp_head); end
  endtask

  task automatic test_flush_recover();
    logic [5:0] e;
    logic [5:0] last;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 6'd0, 1'b0);
      e = exp_q.pop_front();
      n_cmp++; if (alloc_phys !== e) begin n_bad++; $display("FAIL flush_pre_tag[%0d]: got %0d want %0d", i, alloc_phys, e); end
    end
    drive(1'b0, 1'b1, 6'd7, 1'b0);
    drive(1'b1, 1'b0, 6'd0, 1'b1);
    n_cmp++; if (alloc_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %0b want 0", alloc_valid); end
    drive(1'b0, 1'b0, 6'd0, 1'b0);
    n_cmp++; if (alloc_phys !== 6'd33) begin n_bad++; $display("FAIL flush_phys: got %0d want 33", alloc_phys); end
    n_cmp++; if (free_count !== 6'd32) begin n_bad++; $display("FAIL flush_count: got %0d want 32", free_count); end
    last = 6'd0;
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 6'd0, 1'b0);
      n_cmp++; if (free_count !== exp_count) begin n_bad++; $display("FAIL flush_order_count[%0d]: got %0d want %0d", i, free_count, exp_count); end
      if (exp_fire) begin
        e = exp_q.pop_front();
        last = alloc_phys;
        n_cmp++; if (alloc_phys !== e) begin n_bad++; $display("FAIL flush_order_tag[%0d]: got %0d want %0d", i, alloc_phys, e); end
      end
    end
    n_cmp++; if (last !== 6'd7) begin n_bad++; $display("FAIL flush_last_tag: got %0d want 7", last); end
  endtask

  task automatic test_commit_flush_same();
    do_reset();
    drive(1'b1, 1'b0, 6'd0, 1'b0);
    drive(1'b1, 1'b0, 6'd0, 1'b0);
    exp_q.delete();
    drive(1'b1, 1'b1, 6'd11, 1'b1);
    n_cmp++; if (alloc_valid !== 1'b0) begin n_bad++; $display("FAIL cf_valid: got %0b want 0", alloc_valid); end
    n_cmp++; if (free_count !== 6'd30) begin n_bad++; $display("FAIL cf_count_pre: got %0d want 30", free_count); end
    drive(1'b0, 1'b0, 6'd0, 1'b0);
    n_cmp++; if (free_count !== 6'd32) begin n_bad++; $display("FAIL cf_count: got %0d want 32", free_count); end
    n_cmp++; if (alloc_phys !== 6'd33) begin n_bad++; $display("FAIL cf_phys: got %0d want 33", alloc_phys); end
    n_cmp++; if (free_count !== exp_count) begin n_bad++; $display("FAIL cf_count_model: got %0d want %0d", free_count, exp_count); end
    // simultaneous alloc and commit leaves the count unchanged
    drive(1'b1, 1'b0, 6'd0, 1'b0);
    void'(exp_q.pop_front());
    drive(1'b1, 1'b1, 6'd20, 1'b0);
    void'(exp_q.pop_front());
    n_cmp++; if (free_count !== 6'd31) begin n_bad++; $display("FAIL both_pre: got %0d want 31", free_count); end
    drive(1'b0, 1'b0, 6'd0, 1'b0);
    n_cmp++; if (free_count !== 6'd31) begin n_bad++; $display("FAIL both_post: got %0d want 31", free_count); end
    n_cmp++; if (alloc_phys !== exp_head) begin n_bad++; $display("FAIL both_head: got %0d want %0d", alloc_phys, exp_head); end
  endtask

  task automatic test_overflow();
    do_reset();
    drive(1'b0, 1'b1, 6'd9, 1'b0);
    drive(1'b0, 1'b0, 6'd0, 1'b0);
    n_cmp++; if (err_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_full_err: got %0b want 1", err_overflow); end
    n_cmp++; if (free_count !== 6'd32) begin n_bad++; $display("FAIL ovf_full_count: got %0d want 32", free_count); end
    drive(1'b0, 1'b0, 6'd0, 1'b0);
    n_cmp++; if (err_overflow !== exp_err) begin n_bad++; $display("FAIL ovf_sticky: got %0b want %0b", err_overflow, exp_err); end
    do_reset();
    drive(1'b1, 1'b0, 6'd0, 1'b0);
    drive(1'b0, 1'b1, 6'd0, 1'b0);
    drive(1'b0, 1'b0, 6'd0, 1'b0);
    n_cmp++; if (err_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_zero_err: got %0b want 1", err_overflow); end
    n_cmp++; if (free_count !== 6'd31) begin n_bad++; $display("FAIL ovf_zero_count: got %0d want 31", free_count); end
    n_cmp++; if (alloc_phys !== 6'd33) begin n_bad++; $display("FAIL ovf_zero_phys: got %0d want 33", alloc_phys); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 6'd0, 1'b0);
    drive(1'b0, 1'b1, 6'd0, 1'b0);
    drive(1'b1, 1'b0, 6'd0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (alloc_valid !== 1'b1) begin n_bad++; $display("FAIL arst_valid: got %0b want 1", alloc_valid); end
    n_cmp++; if (alloc_phys !== 6'd32) begin n_bad++; $display("FAIL arst_phys: got %0d want 32", alloc_phys); end
    n_cmp++; if (free_count !== 6'd32) begin n_bad++; $display("FAIL arst_count: got %0d want 32", free_count); end
    n_cmp++; if (err_overflow !== 1'b0) begin n_bad++; $display("FAIL arst_err: got %0b want 0", err_overflow); end
    @(negedge clk);
    alloc_req = 1'b0;
    rst_n = 1'b1;
    model_init();
    drive(1'b0, 1'b0, 6'd0, 1'b0);
    n_cmp++; if (free_count !== exp_count) begin n_bad++; $display("FAIL arst_release_count: got %0d want %0d", free_count, exp_count); end
    n_cmp++; if (alloc_phys !== exp_head) begin n_bad++; $display("FAIL arst_release_phys: got %0d want %0d", alloc_phys, exp_head); end
  endtask

  initial begin
    rst_n = 1'b0;
    alloc_req = 1'b0; commit_valid = 1'b0; commit_phys_old = '0; flush = 1'b0;
    model_init();
    test_reset();
    test_back_to_back();
    test_commit_empty();
    test_flush_recover();
    test_commit_flush_same();
    test_overflow();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
